wb_host_master: RTL and testbench
=================================

Name: wb_host_master

Overview:
- Single-outstanding Wishbone classic initiator that drives the user-project Wishbone slave port, i.e. the other end of that interface.
- Takes read/write commands on a valid/ready command channel and runs one Wishbone cycle per command.
- Returns read data and a status code on a valid/ready response channel.
- Used by on-chip test and bring-up logic (LA or UART bridge) to exercise slave register maps without the management SoC.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles with stb high and no ack before the transfer is aborted; 0 disables the timeout.
- TW, 8: width of the timeout counter; must satisfy TIMEOUT_CYCLES < 2**TW.

Ports:
- wb_clk_i  in  1  clock; all logic on its rising edge
- wb_rst_i  in  1  synchronous, active-high reset
- cmd_valid_i  in  1  command offered
- cmd_ready_o  out  1  command accepted when valid&ready
- cmd_we_i  in  1  1=write, 0=read
- cmd_adr_i  in  32  byte address
- cmd_dat_i  in  32  write data
- cmd_sel_i  in  4  byte lane select
- rsp_valid_o  out  1  response available
- rsp_ready_i  in  1  response consumed when valid&ready
- rsp_dat_o  out  32  read data; 0 for writes and timeouts
- rsp_status_o  out  2  00=OK, 01=TIMEOUT, 10/11 reserved (never driven)
- wbm_cyc_o  out  1  Wishbone cycle
- wbm_stb_o  out  1  Wishbone strobe
- wbm_we_o  out  1  Wishbone write enable
- wbm_sel_o  out  4  Wishbone select
- wbm_adr_o  out  32  Wishbone address
- wbm_dat_o  out  32  Wishbone write data
- wbm_ack_i  in  1  slave acknowledge
- wbm_dat_i  in  32  slave read data
- spurious_ack_o  out  1  sticky flag: ack seen while not in BUS

Behaviour:
- Reset: all outputs are 0 at the first edge with wb_rst_i=1, except cmd_ready_o=1 (the IDLE value), registered from the following cycle. The timer clears and state returns to IDLE.
- Reset mid-transfer: cyc and stb drop at that edge, the pending command is discarded, and no response is produced.
- All outputs are registered or decoded from registered state only; there are no combinational input-to-output paths.
- IDLE:
  - cmd_ready_o=1, cyc=stb=0.
  - On cmd_valid_i&cmd_ready_o: latch we/adr/dat/sel, clear the timer, go to BUS.
  - cyc and stb rise on the cycle after acceptance.
- BUS:
  - cyc=stb=1; adr/dat/sel/we stay constant for the whole cycle; cmd_ready_o=0.
  - Timer increments every cycle without ack.
  - ack_i=1: capture wbm_dat_i (for reads; writes capture 0), set status OK, drop cyc/stb at the next edge, go to RESP.
  - Timer==TIMEOUT_CYCLES-1 with no ack (TIMEOUT_CYCLES>0): set status TIMEOUT, rsp_dat=0, drop cyc/stb, go to RESP. stb is therefore high for exactly TIMEOUT_CYCLES cycles.
  - ack_i in the same cycle as timeout expiry: ack wins, status OK.
- RESP:
  - rsp_valid_o=1; rsp_dat_o/rsp_status_o stay stable until the handshake completes.
  - cyc=stb=0, cmd_ready_o=0.
  - On rsp_ready_i: go to IDLE.
  - Backpressure on rsp_ready_i may last indefinitely; no data is lost.
- Spurious ack: wbm_ack_i=1 in IDLE or RESP is ignored for data and sets spurious_ack_o, which is cleared only by reset.
- Latency (best case): accept at cycle N, stb at N+1, ack at N+1, rsp_valid at N+2, rsp_ready at N+2, cmd_ready at N+3. Maximum throughput is one command per 3 cycles.
- The timer saturates; it never wraps.

Decomposition:
- Shared package wb_host_pkg:
  - state enum IDLE/BUS/RESP
  - status codes ST_OK=2'b00, ST_TIMEOUT=2'b01
  - WB_AW=32, WB_DW=32, WB_SW=4
- Sub-module wb_host_timer: a TW-bit saturating counter with clear/enable inputs and an expire output at TIMEOUT_CYCLES-1. It is instantiated once and gated off when TIMEOUT_CYCLES=0.

Test Plan:
- Write, slave acks on the first stb cycle: cmd we=1 adr=0x3000_0004 dat=0xDEAD_BEEF sel=0xF -> stb high 1 cycle with those values on the bus; rsp_valid next cycle, status=00, rsp_dat=0.
- Read, slave acks on the 4th stb cycle with dat_i=0x1234_5678 -> stb high 4 cycles; rsp_dat=0x1234_5678, status=00.
- Timeout, TIMEOUT_CYCLES=8, slave never acks -> stb high exactly 8 cycles, then cyc=0, status=01, rsp_dat=0.
- Ack coincides with the 8th cycle (TIMEOUT_CYCLES=8) -> status=00 with the captured data.
- Response backpressure: hold rsp_ready=0 for 10 cycles -> rsp_valid/dat/status stable, cmd_ready=0, no new bus cycle.
- Assert reset on the 2nd stb cycle -> cyc/stb=0 at that edge, no rsp_valid, cmd_ready=1 after reset. Separately, ack while IDLE -> spurious_ack_o=1 and it stays set.

Source files
------------

// File: rtl/wb_host_pkg.sv
// Shared types and constants for the Wishbone host master.
package wb_host_pkg;

    localparam int unsigned WB_AW = 32;
    localparam int unsigned WB_DW = 32;
    localparam int unsigned WB_SW = 4;
    localparam int unsigned ST_W  = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic [ST_W-1:0] ST_OK      = 2'b00;
    localparam logic [ST_W-1:0] ST_TIMEOUT = 2'b01;

    // Command latched at acceptance and held on the bus for the whole cycle.
    typedef struct packed {
        logic             we;
        logic [WB_AW-1:0] adr;
        logic [WB_DW-1:0] dat;
        logic [WB_SW-1:0] sel;
    } cmd_t;

endpackage

// File: rtl/wb_host_timer.sv
// Saturating bus-cycle timer; flags expiry on the last allowed stb cycle.
module wb_host_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned TW             = 8
) (
    input  logic wb_clk_i,
    input  logic wb_rst_i,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);

    logic [TW-1:0] r_cnt;

    // Count enabled cycles, holding at all-ones instead of wrapping.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != '1)) begin
            r_cnt <= r_cnt + TW'(1);
        end
    end

    assign o_expire = (r_cnt == TW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/wb_host_master.sv
// Single-outstanding Wishbone classic initiator with valid/ready command and response channels.
module wb_host_master
    import wb_host_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned TW             = 8
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic             cmd_we_i,
    input  logic [WB_AW-1:0] cmd_adr_i,
    input  logic [WB_DW-1:0] cmd_dat_i,
    input  logic [WB_SW-1:0] cmd_sel_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [WB_DW-1:0] rsp_dat_o,
    output logic [ST_W-1:0]  rsp_status_o,
    output logic             wbm_cyc_o,
    output logic             wbm_stb_o,
    output logic             wbm_we_o,
    output logic [WB_SW-1:0] wbm_sel_o,
    output logic [WB_AW-1:0] wbm_adr_o,
    output logic [WB_DW-1:0] wbm_dat_o,
    input  logic             wbm_ack_i,
    input  logic [WB_DW-1:0] wbm_dat_i,
    output logic             spurious_ack_o
);

    state_e           r_state;
    state_e           w_state_nxt;
    cmd_t             r_cmd;
    logic [WB_DW-1:0] r_rsp_dat;
    logic [ST_W-1:0]  r_rsp_status;
    logic             r_spurious;

    logic w_accept;
    logic w_done_ok;
    logic w_done_to;
    logic w_timer_clr;
    logic w_timer_en;
    logic w_expire;

    // Timeout timer exists only when a timeout is configured.
    generate
        if (TIMEOUT_CYCLES > 0) begin : g_timer
            wb_host_timer #(
                .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
                .TW             (TW)
            ) u_timer (
                .wb_clk_i (wb_clk_i),
                .wb_rst_i (wb_rst_i),
                .i_clr    (w_timer_clr),
                .i_en     (w_timer_en),
                .o_expire (w_expire)
            );
        end else begin : g_no_timer
            assign w_expire = 1'b0;
        end
    endgenerate

    // State register.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and control decode; ack takes priority over timeout expiry.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_done_ok   = 1'b0;
        w_done_to   = 1'b0;
        w_timer_clr = 1'b0;
        w_timer_en  = 1'b0;
        case (r_state)
            IDLE: begin
                if (cmd_valid_i) begin
                    w_accept    = 1'b1;
                    w_timer_clr = 1'b1;
                    w_state_nxt = BUS;
                end
            end
            BUS: begin
                if (wbm_ack_i) begin
                    w_done_ok   = 1'b1;
                    w_state_nxt = RESP;
                end else if (w_expire) begin
                    w_done_to   = 1'b1;
                    w_state_nxt = RESP;
                end else begin
                    w_timer_en  = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Command latch, response capture and sticky spurious-ack flag.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_cmd        <= '0;
            r_rsp_dat    <= '0;
            r_rsp_status <= ST_OK;
            r_spurious   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_cmd.we  <= cmd_we_i;
                r_cmd.adr <= cmd_adr_i;
                r_cmd.dat <= cmd_dat_i;
                r_cmd.sel <= cmd_sel_i;
            end
            if (w_done_ok) begin
                r_rsp_dat    <= r_cmd.we ? '0 : wbm_dat_i;
                r_rsp_status <= ST_OK;
            end else if (w_done_to) begin
                r_rsp_dat    <= '0;
                r_rsp_status <= ST_TIMEOUT;
            end
            if (wbm_ack_i && (r_state != BUS)) begin
                r_spurious <= 1'b1;
            end
        end
    end

    assign cmd_ready_o    = (r_state == IDLE);
    assign rsp_valid_o    = (r_state == RESP);
    assign wbm_cyc_o      = (r_state == BUS);
    assign wbm_stb_o      = (r_state == BUS);
    assign wbm_we_o       = r_cmd.we;
    assign wbm_adr_o      = r_cmd.adr;
    assign wbm_dat_o      = r_cmd.dat;
    assign wbm_sel_o      = r_cmd.sel;
    assign rsp_dat_o      = r_rsp_dat;
    assign rsp_status_o   = r_rsp_status;
    assign spurious_ack_o = r_spurious;

endmodule

// File: tb/tb_wb_host_master.sv
// Scoreboard bench for wb_host_master with a scripted Wishbone slave.
module tb_wb_host_master;
    import wb_host_pkg::*;

    localparam int unsigned TO = 8;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i = 1'b1;
    logic        cmd_valid_i = 1'b0;
    logic        cmd_ready_o;
    logic        cmd_we_i = 1'b0;
    logic [31:0] cmd_adr_i = '0;
    logic [31:0] cmd_dat_i = '0;
    logic [3:0]  cmd_sel_i = '0;
    logic        rsp_valid_o;
    logic        rsp_ready_i = 1'b0;
    logic [31:0] rsp_dat_o;
    logic [1:0]  rsp_status_o;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic        wbm_ack_i = 1'b0;
    logic [31:0] wbm_dat_i = '0;
    logic        spurious_ack_o;

    wb_host_master #(.TIMEOUT_CYCLES(TO), .TW(8)) dut (
        .wb_clk_i       (wb_clk_i),
        .wb_rst_i       (wb_rst_i),
        .cmd_valid_i    (cmd_valid_i),
        .cmd_ready_o    (cmd_ready_o),
        .cmd_we_i       (cmd_we_i),
        .cmd_adr_i      (cmd_adr_i),
        .cmd_dat_i      (cmd_dat_i),
        .cmd_sel_i      (cmd_sel_i),
        .rsp_valid_o    (rsp_valid_o),
        .rsp_ready_i    (rsp_ready_i),
        .rsp_dat_o      (rsp_dat_o),
        .rsp_status_o   (rsp_status_o),
        .wbm_cyc_o      (wbm_cyc_o),
        .wbm_stb_o      (wbm_stb_o),
        .wbm_we_o       (wbm_we_o),
        .wbm_sel_o      (wbm_sel_o),
        .wbm_adr_o      (wbm_adr_o),
        .wbm_dat_o      (wbm_dat_o),
        .wbm_ack_i      (wbm_ack_i),
        .wbm_dat_i      (wbm_dat_i),
        .spurious_ack_o (spurious_ack_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] dat;
        logic [1:0]  st;
    } rsp_t;
    rsp_t exp_q[$];

    // Slave script and expected bus contents for the current command.
    int          ack_at = 0;
    logic [31:0] rdata = '0;
    logic        force_spurious = 1'b0;
    int          stb_cycles = 0;
    logic        exp_we = 1'b0;
    logic [31:0] exp_adr = '0;
    logic [31:0] exp_dat = '0;
    logic [3:0]  exp_sel = '0;

    // Slave: count stb cycles, check bus values, ack on the scripted cycle.
    always @(negedge wb_clk_i) begin
        if (wbm_stb_o) begin
            stb_cycles++;
            chk("bus_cyc", 32'(wbm_cyc_o), 32'd1);
            chk("bus_we",  32'(wbm_we_o), 32'(exp_we));
            chk("bus_adr", wbm_adr_o, exp_adr);
            chk("bus_dat", wbm_dat_o, exp_dat);
            chk("bus_sel", 32'(wbm_sel_o), 32'(exp_sel));
            wbm_ack_i = (ack_at != 0) && (stb_cycles == ack_at);
            wbm_dat_i = wbm_ack_i ? rdata : 32'hBAD0_BAD0;
        end else begin
            wbm_ack_i = force_spurious;
            wbm_dat_i = 32'hBAD0_BAD0;
        end
    end

    // Monitor: pop and compare on each response handshake; check stability while stalled.
    logic        stall_prev = 1'b0;
    logic [31:0] prev_dat = '0;
    logic [1:0]  prev_st = '0;
    always @(negedge wb_clk_i) begin
        rsp_t e;
        if (!wb_rst_i && rsp_valid_o) begin
            if (stall_prev) begin
                chk("rsp_dat_stable", rsp_dat_o, prev_dat);
                chk("rsp_status_stable", 32'(rsp_status_o), 32'(prev_st));
            end
            if (rsp_ready_i) begin
                stall_prev = 1'b0;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp actual dat=%h status=%0d required none", rsp_dat_o, rsp_status_o);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_dat", rsp_dat_o, e.dat);
                    chk("rsp_status", 32'(rsp_status_o), 32'(e.st));
                end
            end else begin
                stall_prev = 1'b1;
                prev_dat   = rsp_dat_o;
                prev_st    = rsp_status_o;
            end
        end else begin
            stall_prev = 1'b0;
        end
    end

    // Offer one command; wait for accept and response; hold rsp_ready low for 'hold' cycles.
    task automatic run(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, input int ack_i, input logic [31:0] rd,
                       input logic [31:0] e_dat, input logic [1:0] e_st, input int e_len,
                       input int hold);
        int ok;
        int lat;
        @(posedge wb_clk_i); #1;
        ack_at = ack_i; rdata = rd; stb_cycles = 0;
        exp_we = we; exp_adr = adr; exp_dat = dat; exp_sel = sel;
        cmd_we_i = we; cmd_adr_i = adr; cmd_dat_i = dat; cmd_sel_i = sel;
        cmd_valid_i = 1'b1;
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge wb_clk_i);
            if (cmd_ready_o) begin ok = 1; break; end
        end
        chk("cmd_accept_wait", 32'(ok), 32'd1);
        @(posedge wb_clk_i); #1;
        cmd_valid_i = 1'b0;
        exp_q.push_back('{e_dat, e_st});
        ok = 0; lat = 0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge wb_clk_i);
            if (rsp_valid_o) begin ok = 1; lat = i; break; end
        end
        chk("rsp_wait", 32'(ok), 32'd1);
        chk("rsp_latency", 32'(lat), 32'(e_len + 1));
        for (int i = 0; i < hold; i++) begin
            chk("cmd_ready_in_resp", 32'(cmd_ready_o), 32'd0);
            chk("stb_in_resp", 32'(wbm_stb_o), 32'd0);
            chk("rsp_valid_held", 32'(rsp_valid_o), 32'd1);
            @(negedge wb_clk_i);
        end
        @(posedge wb_clk_i); #1;
        rsp_ready_i = 1'b1;
        @(posedge wb_clk_i); #1;
        rsp_ready_i = 1'b0;
        @(negedge wb_clk_i);
        chk("stb_len", 32'(stb_cycles), 32'(e_len));
        chk("cmd_ready_after_rsp", 32'(cmd_ready_o), 32'd1);
        chk("rsp_valid_after_rsp", 32'(rsp_valid_o), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge wb_clk_i);
        @(negedge wb_clk_i);
        chk("rst_cmd_ready", 32'(cmd_ready_o), 32'd1);
        chk("rst_cyc", 32'(wbm_cyc_o), 32'd0);
        chk("rst_stb", 32'(wbm_stb_o), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        chk("rst_adr", wbm_adr_o, 32'd0);
        chk("rst_spurious", 32'(spurious_ack_o), 32'd0);
        @(posedge wb_clk_i); #1;
        wb_rst_i = 1'b0;

        // Write acked on first stb cycle: write response data is 0.
        run(1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF, 1, 32'h5555_AAAA, 32'h0, ST_OK, 1, 0);
        // Read acked on the 4th stb cycle.
        run(1'b0, 32'h3000_0010, 32'h0, 4'hF, 4, 32'h1234_5678, 32'h1234_5678, ST_OK, 4, 0);
        // Slave never acks: timeout after exactly 8 stb cycles.
        run(1'b0, 32'h3000_0020, 32'h0, 4'hF, 0, 32'h0, 32'h0, ST_TIMEOUT, 8, 0);
        // Ack coincides with the last allowed cycle: ack wins.
        run(1'b0, 32'h3000_0024, 32'h0, 4'hF, 8, 32'hCAFE_F00D, 32'hCAFE_F00D, ST_OK, 8, 0);
        // Response backpressure for 10 cycles.
        run(1'b0, 32'h3000_0028, 32'h0, 4'hF, 2, 32'hA5A5_0F0F, 32'hA5A5_0F0F, ST_OK, 2, 10);
        // Partial-lane write.
        run(1'b1, 32'h3000_0102, 32'h0000_BEEF, 4'h3, 3, 32'h7777_7777, 32'h0, ST_OK, 3, 2);

        // Reset during the 2nd stb cycle: bus drops, no response.
        @(posedge wb_clk_i); #1;
        ack_at = 0; stb_cycles = 0;
        exp_we = 1'b0; exp_adr = 32'h3000_0200; exp_dat = 32'h0; exp_sel = 4'hF;
        cmd_we_i = 1'b0; cmd_adr_i = 32'h3000_0200; cmd_dat_i = 32'h0; cmd_sel_i = 4'hF;
        cmd_valid_i = 1'b1;
        @(posedge wb_clk_i); #1;
        cmd_valid_i = 1'b0;
        @(posedge wb_clk_i); #1;
        wb_rst_i = 1'b1;
        @(negedge wb_clk_i);
        chk("pre_rst_stb", 32'(wbm_stb_o), 32'd1);
        @(negedge wb_clk_i);
        chk("midrst_cyc", 32'(wbm_cyc_o), 32'd0);
        chk("midrst_stb", 32'(wbm_stb_o), 32'd0);
        chk("midrst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        chk("midrst_cmd_ready", 32'(cmd_ready_o), 32'd1);
        @(posedge wb_clk_i); #1;
        wb_rst_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge wb_clk_i);
            chk("postrst_rsp_valid", 32'(rsp_valid_o), 32'd0);
            chk("postrst_stb", 32'(wbm_stb_o), 32'd0);
        end

        // Normal operation after reset.
        run(1'b0, 32'h3000_0300, 32'h0, 4'hF, 1, 32'h0BAD_C0DE, 32'h0BAD_C0DE, ST_OK, 1, 0);

        // Ack while idle sets the sticky flag.
        chk("spurious_before", 32'(spurious_ack_o), 32'd0);
        @(posedge wb_clk_i); #1;
        force_spurious = 1'b1;
        @(posedge wb_clk_i); #1;
        force_spurious = 1'b0;
        @(negedge wb_clk_i);
        chk("spurious_set", 32'(spurious_ack_o), 32'd1);
        chk("spurious_no_bus", 32'(wbm_stb_o), 32'd0);
        chk("spurious_no_rsp", 32'(rsp_valid_o), 32'd0);
        repeat (5) @(negedge wb_clk_i);
        chk("spurious_sticky", 32'(spurious_ack_o), 32'd1);
        run(1'b1, 32'h3000_0400, 32'h1111_2222, 4'hC, 2, 32'h0, 32'h0, ST_OK, 2, 0);
        chk("spurious_sticky_after_txn", 32'(spurious_ack_o), 32'd1);

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
